serial_adder_ctrl: RTL and testbench
====================================

Name: serial_adder_ctrl

Overview:
Bit-serial adder controller that sequences a single 1-bit full-adder cell over WIDTH cycles to add two WIDTH-bit operands.
- Uses a start/busy/done handshake, operand shift registers, a carry flip-flop and a bit counter.
- Sits between a requester and the adder cell, trading area for latency. One result per WIDTH+1 cycles.

Parameters:
- WIDTH, 8, operand/result width in bits (WIDTH >= 2).
- CNT_W, $clog2(WIDTH+1), bit-counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when busy=0
- a  input  WIDTH  operand A; captured on accepted start
- b  input  WIDTH  operand B; captured on accepted start
- busy  output  1  high while an addition is in progress
- done  output  1  one-cycle pulse; result valid
- sum  output  WIDTH  registered result; holds last result
- carry_out  output  1  registered final carry; holds last result

Behaviour:
- Single clock clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, sum=0, carry_out=0, carry FF=0, count=0, shift registers=0.
- States:
  - IDLE: busy=0, done=0.
  - RUN: busy=1.
  - DONE: busy=0, done=1, for exactly one cycle.
- Start acceptance:
  - start=1 at edge E0 while state is IDLE or DONE: load a_r=a, b_r=b, carry=0, count=0, go to RUN.
  - start while RUN: ignored, with no effect on operands or count.
- RUN, each edge:
  - The cell computes s = a_r[0]^b_r[0]^carry and c = majority(a_r[0], b_r[0], carry).
  - s shifts into s_r at the MSB. a_r and b_r shift right with zero fill. carry <= c. count++.
- Edges E1..EWIDTH process bits 0..WIDTH-1.
- At edge EWIDTH (count==WIDTH-1 before the edge): sum <= final s_r (including this bit), carry_out <= c, go to DONE.
- done is high between edges EWIDTH and EWIDTH+1. busy is high between E0 and EWIDTH.
- Latency: start accepted at E0 gives done visible after EWIDTH. Throughput is one op per WIDTH+1 edges, back-to-back.
- DONE exits to RUN if start=1, otherwise to IDLE.
- sum and carry_out change only on the transition into DONE (or on reset). They are stable during RUN and IDLE.
- Arithmetic is unsigned modulo 2^WIDTH. carry_out is bit WIDTH of a+b.
- Reset mid-operation discards the operation:
  - All state returns to reset values on that edge.
  - No done pulse is produced.
  - sum and carry_out go to 0.
- rst has priority over start on the same edge.

Decomposition:
- Shared package/header holds:
  - State encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2. Encoding 2'd3 recovers to IDLE.
  - Default WIDTH constant.
- Sub-module full_adder_cell (a, b, cin -> s, cout) is purely combinational. It is built from two half-adder instances plus an OR, and is instantiated once.
- FSM, counter and shift registers stay in serial_adder_ctrl.

Test Plan:
All cases use WIDTH=8.
1. Pulse start with a=8'h0F, b=8'h01.
   - Expect busy=1 for exactly 8 cycles.
   - Then done=1 for 1 cycle with sum=8'h10, carry_out=0.
2. a=8'hFF, b=8'h01.
   - Expect sum=8'h00, carry_out=1.
   - Then a=8'hFF, b=8'hFF: expect sum=8'hFE, carry_out=1.
3. Start a=8'h12, b=8'h34, then assert start with a=8'hFF at the 3rd busy cycle.
   - Expect the second start to be ignored.
   - Expect sum=8'h46, carry_out=0, with done at the 8-edge latency.
4. Start a=8'hAA, b=8'h55, then assert rst at the 4th busy cycle.
   - Expect busy=0, done never pulses, sum=0, carry_out=0.
   - A following start with a=8'h01, b=8'h01 yields sum=8'h02.
5. Hold start=1 continuously with new operands presented in each done cycle.
   - Expect done every 9 edges and no lost or duplicated results.
6. Random: 200 operand pairs.
   - Compare {carry_out, sum} to a+b at each done.
   - Check sum is stable on every non-done cycle.

Source files
------------

// File: rtl/serial_adder_ctrl_pkg.sv
// serial_adder_ctrl_pkg: shared state encoding and default width for the serial adder
package serial_adder_ctrl_pkg;
  localparam int DEFAULT_WIDTH = 8;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/serial_adder_ctrl_cell.sv
// serial_adder_ctrl_cell: combinational full-adder cell built from two half adders and an OR
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  logic s0, c0, c1;
  half_adder u_ha0 (.a(a), .b(b), .s(s0), .c(c0));
  half_adder u_ha1 (.a(s0), .b(cin), .s(s), .c(c1));
  assign cout = c0 | c1;
endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial adder sequencing one full-adder cell over WIDTH cycles
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);
  state_t state, state_nxt;
  logic [WIDTH-1:0] a_r, b_r, s_r;
  logic [CNT_W-1:0] count;
  logic carry, s, c, accept, last;
  full_adder_cell u_cell (.a(a_r[0]), .b(b_r[0]), .cin(carry), .s(s), .cout(c));
  assign busy   = state == ST_RUN;
  assign done   = state == ST_DONE;
  assign accept = start && (state == ST_IDLE || state == ST_DONE);
  assign last   = count == CNT_W'(WIDTH - 1);
  always_comb begin
    state_nxt = ST_IDLE;
    state_nxt = busy ? (last ? ST_DONE : ST_RUN) : accept ? ST_RUN : ST_IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      a_r       <= '0;
      b_r       <= '0;
      s_r       <= '0;
      carry     <= 1'b0;
      count     <= '0;
      sum       <= '0;
      carry_out <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        a_r   <= a;
        b_r   <= b;
        carry <= 1'b0;
        count <= '0;
      end else if (busy) begin
        a_r   <= a_r >> 1;
        b_r   <= b_r >> 1;
        s_r   <= {s, s_r[WIDTH-1:1]};
        carry <= c;
        count <= count + 1'b1;
        if (last) begin
          sum       <= {s, s_r[WIDTH-1:1]};
          carry_out <= c;
        end
      end
    end
  end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: vector table, corner sequences and randomized checks against a+b
module tb_serial_adder_ctrl;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst, start, busy, done, carry_out;
  logic [W-1:0] a, b, sum;
  int checks = 0, errors = 0, cyc = 0;
  typedef struct {
    logic [W-1:0] a, b, s;
    logic co;
  } vec_t;
  vec_t vecs[7];

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .sum(sum), .carry_out(carry_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_op(input logic [W-1:0] va, input logic [W-1:0] vb,
                        output logic [W-1:0] rs, output logic rco,
                        output int nbusy, output int lat);
    a = va;
    b = vb;
    start = 1'b1;
    tick();
    start = 1'b0;
    nbusy = 0;
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) break;
      if (busy) nbusy++;
      tick();
      lat++;
    end
    rs = sum;
    rco = carry_out;
  endtask

  initial begin
    logic [W-1:0] rs;
    logic rco;
    int nbusy, lat, k, prev_done, start_cyc, ndone;
    logic [W:0] exp_q[5];
    logic [W-1:0] op_a[5], op_b[5];
    logic [W:0] last_res, exp;
    logic [W-1:0] ra, rb;
    vecs[0] = '{8'h0F, 8'h01, 8'h10, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 8'hFE, 1'b1};
    vecs[3] = '{8'h12, 8'h34, 8'h46, 1'b0};
    vecs[4] = '{8'h80, 8'h80, 8'h00, 1'b1};
    vecs[5] = '{8'h00, 8'h00, 8'h00, 1'b0};
    vecs[6] = '{8'hA5, 8'h5A, 8'hFF, 1'b0};
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    tick();
    tick();
    rst = 1'b0;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_sum", 32'(sum), 32'd0);
    chk("reset_co", 32'(carry_out), 32'd0);

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, rs, rco, nbusy, lat);
      chk("vec_done", 32'(done), 32'd1);
      chk("vec_busy_cycles", 32'(nbusy), 32'd8);
      chk("vec_sum", 32'(rs), 32'(vecs[i].s));
      chk("vec_co", 32'(rco), 32'(vecs[i].co));
      tick();
      chk("vec_done_one_cycle", 32'(done), 32'd0);
    end

    a = 8'h12;
    b = 8'h34;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    a = 8'hFF;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 3;
    for (int i = 0; i < 20; i++) begin
      if (done) break;
      tick();
      lat++;
    end
    chk("ignore_latency", 32'(lat), 32'd8);
    chk("ignore_sum", 32'(sum), 32'h46);
    chk("ignore_co", 32'(carry_out), 32'd0);
    tick();

    a = 8'hAA;
    b = 8'h55;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_sum", 32'(sum), 32'd0);
    chk("abort_co", 32'(carry_out), 32'd0);
    ndone = 0;
    repeat (12) begin
      tick();
      if (done) ndone++;
    end
    chk("abort_no_done", 32'(ndone), 32'd0);
    run_op(8'h01, 8'h01, rs, rco, nbusy, lat);
    chk("after_abort_sum", 32'(rs), 32'h02);
    chk("after_abort_latency", 32'(lat), 32'd8);
    tick();

    for (int i = 0; i < 5; i++) begin
      op_a[i] = W'($urandom);
      op_b[i] = W'($urandom);
      exp_q[i] = {1'b0, op_a[i]} + {1'b0, op_b[i]};
    end
    a = op_a[0];
    b = op_b[0];
    start = 1'b1;
    tick();
    start_cyc = cyc;
    prev_done = 0;
    k = 0;
    for (int i = 0; i < 100; i++) begin
      if (done) begin
        chk("b2b_result", 32'({carry_out, sum}), 32'(exp_q[k]));
        chk("b2b_spacing", 32'(cyc - (k == 0 ? start_cyc - 1 : prev_done)), 32'(k == 0 ? 9 : 9));
        prev_done = cyc;
        k++;
        if (k == 5) begin
          start = 1'b0;
          break;
        end
        a = op_a[k];
        b = op_b[k];
      end
      tick();
    end
    chk("b2b_count", 32'(k), 32'd5);
    ndone = 0;
    repeat (12) begin
      tick();
      if (done) ndone++;
    end
    chk("b2b_no_extra", 32'(ndone), 32'd0);
    last_res = exp_q[4];

    for (int n = 0; n < 200; n++) begin
      repeat ($urandom_range(0, 2)) begin
        chk("rnd_idle_sum", 32'({carry_out, sum}), 32'(last_res));
        chk("rnd_idle_done", 32'(done), 32'd0);
        tick();
      end
      ra = W'($urandom);
      rb = W'($urandom);
      exp = {1'b0, ra} + {1'b0, rb};
      a = ra;
      b = rb;
      start = 1'b1;
      tick();
      lat = 0;
      for (int i = 0; i < 20; i++) begin
        if (done) break;
        chk("rnd_run_sum", 32'({carry_out, sum}), 32'(last_res));
        start = 1'($urandom);
        a = W'($urandom);
        b = W'($urandom);
        tick();
        lat++;
      end
      start = 1'b0;
      chk("rnd_latency", 32'(lat), 32'd8);
      chk("rnd_result", 32'({carry_out, sum}), 32'(exp));
      last_res = exp;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
